// File: rtl/delay_line_prog_pkg.sv
// Shared defaults and lane helpers for the programmable delay line.
// Imported by delay_line_prog and delay_line_prog_ram.
package delay_line_prog_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int CHANNELS_DEF  = 2;
  localparam int MAX_DEPTH_DEF = 16;

  // Bit offset of lane 'lane' inside a flat CHANNELS*WIDTH bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/delay_line_prog_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// The read is combinational, so a same-edge read and write sees the old word.
module delay_line_prog_ram
  import delay_line_prog_pkg::*;
#(
  parameter int DATA_W = WIDTH_DEF * CHANNELS_DEF,
  parameter int DEPTH  = MAX_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_line_prog.sv
// Runtime-programmable delay line: CHANNELS lanes delayed by dnum valid samples.
// Optional synchronous flush port enabled by defining DELAY_FLUSH_EN.
module delay_line_prog
  import delay_line_prog_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int DNUM_W    = $clog2(MAX_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DNUM_W-1:0]         dnum,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef DELAY_FLUSH_EN
  input  logic                      flush,
`endif
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      fill_done
);

  localparam int DW = CHANNELS * WIDTH;
  localparam logic [DNUM_W-1:0] FILL_MAX = DNUM_W'(MAX_DEPTH - 1);

  logic [DNUM_W-1:0] wr_ptr, rd_addr, dnum_q, fill_cnt, fill_nxt;
  logic [DW-1:0]     rd_data, dly_data;
  logic              dnum_chg, flush_i, wr_en;

`ifdef DELAY_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign dnum_chg = (dnum != dnum_q);
  assign rd_addr  = wr_ptr - dnum_q;
  // A flushed sample is dropped entirely, including its RAM write.
  assign wr_en    = in_valid & ~flush_i;

  delay_line_prog_ram #(
    .DATA_W (DW),
    .DEPTH  (MAX_DEPTH),
    .ADDR_W (DNUM_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Zero delay bypasses the RAM so the sample leaves one clock after entry.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign dly_data[i*WIDTH +: WIDTH] = (dnum_q == '0) ? in_data[i*WIDTH +: WIDTH]
                                                       : rd_data[i*WIDTH +: WIDTH];
  end

  // A delay change restarts fill accounting even if a sample is written this cycle.
  always_comb begin
    fill_nxt = fill_cnt;
    if (dnum_chg)
      fill_nxt = '0;
    else if (in_valid && fill_cnt != FILL_MAX)
      fill_nxt = fill_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dnum_q    <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      fill_done <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      dnum_q <= dnum;
      if (flush_i) begin
        wr_ptr    <= '0;
        fill_cnt  <= '0;
        fill_done <= 1'b0;
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        fill_cnt  <= fill_nxt;
        fill_done <= !dnum_chg && (fill_nxt >= dnum_q);
        out_valid <= in_valid && (fill_cnt >= dnum_q);
        if (in_valid) begin
          wr_ptr   <= wr_ptr + 1'b1;
          out_data <= dly_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed self-checking bench for delay_line_prog (default 16-bit x 2 lanes, depth 16).
module tb_delay_line_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dnum;
  logic        in_valid;
  logic [31:0] in_data;
`ifdef DELAY_FLUSH_EN
  logic        flush;
`endif
  logic        out_valid;
  logic [31:0] out_data;
  logic        fill_done;

  int pass_cnt = 0;
  int total    = 0;

  logic [15:0] s [64];

  delay_line_prog dut (
    .clk       (clk),
    .rst       (rst),
    .dnum      (dnum),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef DELAY_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .fill_done (fill_done)
  );

  always #5 clk = ~clk;

  // Lane 1 carries a distinct but related word so lane swaps are visible.
  function automatic logic [31:0] mk(input logic [15:0] v);
    return {v ^ 16'hA5A5, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; dnum = 4'd4; in_valid = 1'b0; in_data = '0;
`ifdef DELAY_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: dnum=4, first sample -0.7071 appears after the 5th strobe
    s[0] = 16'hFF4B;
    for (int k = 1; k < 8; k++) s[k] = 16'(k);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
      chk($sformatf("t1_valid_%0d", k), 32'(out_valid), 32'(k >= 4));
      chk($sformatf("t1_fill_%0d", k),  32'(fill_done), 32'(k >= 3));
      if (k >= 4) chk($sformatf("t1_data_%0d", k), out_data, mk(s[k-4]));
    end

    // 2: zero delay bypass
    in_valid = 1'b0; dnum = 4'd0;
    tick();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = mk(16'(16'h0010 * (k + 1)));
      tick();
      chk($sformatf("t2_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("t2_data_%0d", k),  out_data, mk(16'(16'h0010 * (k + 1))));
    end

    // 3: dnum=3 with alternating strobes
    in_valid = 1'b0; dnum = 4'd3;
    tick();
    for (int k = 0; k < 7; k++) begin
      s[k] = 16'(16'h8100 + k);
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
      chk($sformatf("t3_valid_%0d", k), 32'(out_valid), 32'(k >= 3));
      if (k >= 3) chk($sformatf("t3_data_%0d", k), out_data, mk(s[k-3]));
      in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
      tick();
      chk($sformatf("t3_idle_valid_%0d", k), 32'(out_valid), 32'd0);
      if (k >= 3) chk($sformatf("t3_idle_hold_%0d", k), out_data, mk(s[k-3]));
    end

    // 4: fill at dnum=4, then switch to 2 during an idle cycle
    dnum = 4'd4;
    tick();
    for (int k = 0; k < 11; k++) s[k] = 16'(16'h0200 + k);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
      if (k >= 4) chk($sformatf("t4_pre_data_%0d", k), out_data, mk(s[k-4]));
    end
    in_valid = 1'b0; dnum = 4'd2;
    tick();
    chk("t4_chg_fill", 32'(fill_done), 32'd0);
    for (int k = 6; k < 11; k++) begin
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
      chk($sformatf("t4_valid_%0d", k), 32'(out_valid), 32'(k >= 8));
      if (k >= 8) chk($sformatf("t4_data_%0d", k), out_data, mk(s[k-2]));
    end

    // 5: maximum delay with pointer wrap
    in_valid = 1'b0; dnum = 4'd15;
    tick();
    for (int k = 0; k < 40; k++) begin
      s[k] = 16'(16'hC300 + 7 * k);
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
      chk($sformatf("t5_valid_%0d", k), 32'(out_valid), 32'(k >= 15));
      chk($sformatf("t5_fill_%0d", k),  32'(fill_done), 32'(k >= 14));
      if (k >= 15) chk($sformatf("t5_data_%0d", k), out_data, mk(s[k-15]));
    end

    // 6: async reset while output is valid
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data",  out_data,       32'd0);
    chk("t6_rst_fill",  32'(fill_done), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    // fill restarts from zero after release (dnum_q was cleared, dnum=15 reloads)
    tick();
    in_valid = 1'b1; in_data = mk(16'h0777);
    tick();
    chk("t6_post_valid", 32'(out_valid), 32'd0);
    chk("t6_post_fill",  32'(fill_done), 32'd0);

`ifdef DELAY_FLUSH_EN
    in_valid = 1'b0; dnum = 4'd2;
    tick();
    for (int k = 0; k < 4; k++) begin
      s[k] = 16'(16'h0500 + k);
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
    end
    chk("t6f_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = mk(16'h0BAD);
    tick();
    flush = 1'b0;
    chk("t6f_valid", 32'(out_valid), 32'd0);
    chk("t6f_data",  out_data,       32'd0);
    chk("t6f_fill",  32'(fill_done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      s[k] = 16'(16'h0600 + k);
      in_valid = 1'b1; in_data = mk(s[k]);
      tick();
      chk($sformatf("t6f_rs_valid_%0d", k), 32'(out_valid), 32'(k >= 2));
      if (k >= 2) chk($sformatf("t6f_rs_data_%0d", k), out_data, mk(s[k-2]));
    end
`endif

    in_valid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
